// File: rtl/attr_expander_pkg.sv
// attr_expander_pkg: shared PPU constants, FSM states and tile-offset helper for attr_expander.
package attr_expander_pkg;
   localparam logic [9:0] ATTR_TABLE_OFS = 10'h3C0;
   localparam int NT_COLS = 32;
   localparam int NT_ROWS_DEFAULT = 30;
   typedef enum logic {IDLE = 1'b0, EXPAND = 1'b1} state_t;
   // Offset of the tile inside its nametable: row r = arow*4+sub_row, col c = acol*4+sub_col.
   function automatic logic [9:0] tile_ofs(input logic [2:0] arow, input logic [2:0] acol, input logic [3:0] cnt);
      return 10'({arow, cnt[3:2]} * NT_COLS + {acol, cnt[1:0]});
   endfunction
endpackage

// File: rtl/attr_quadrant_sel.sv
// attr_quadrant_sel: picks a tile's 2-bit palette out of an attribute byte.
// Ports: attr_data (attribute byte), r1/c1 (bit 1 of tile row/col), tile_pal (palette index).
module attr_quadrant_sel (
   input  logic [7:0] attr_data,
   input  logic       r1,
   input  logic       c1,
   output logic [1:0] tile_pal
);
   assign tile_pal = attr_data[{r1, c1, 1'b0} +: 2];
endmodule

// File: rtl/attr_expander.sv
// attr_expander: expands one attribute-byte write into per-tile palette writes, one per cycle.
// Ports: clk/rst (sync active-high), attr_valid/attr_ready/attr_addr/attr_data (request),
// tile_wr_en/tile_wr_addr/tile_pal (tile write), done (end of request), err (rejected request).
// Macro ATTR_EXP_BACKPRESSURE_EN adds input tile_wr_ready to stall tile writes.
module attr_expander
   import attr_expander_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int NT_ROWS = NT_ROWS_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              attr_valid,
   output logic              attr_ready,
   input  logic [ADDR_W-1:0] attr_addr,
   input  logic [7:0]        attr_data,
`ifdef ATTR_EXP_BACKPRESSURE_EN
   input  logic              tile_wr_ready,
`endif
   output logic              tile_wr_en,
   output logic [ADDR_W-1:0] tile_wr_addr,
   output logic [1:0]        tile_pal,
   output logic              done,
   output logic              err
);
   state_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d, cnt_n;
   logic [ADDR_W-1:0] base_q, base_d, in_base, sel_base, nxt_addr, tile_wr_addr_q, tile_wr_addr_d;
   logic [2:0] arow_q, arow_d, acol_q, acol_d, sel_arow, sel_acol;
   logic [7:0] data_q, data_d, sel_data;
   logic [1:0] nxt_pal, tile_pal_q, tile_pal_d;
   logic attr_ready_q, attr_ready_d, tile_wr_en_q, tile_wr_en_d, done_q, done_d, err_q, err_d;
   logic idle, in_ok, wr_done, last;
`ifdef ATTR_EXP_BACKPRESSURE_EN
   assign wr_done = tile_wr_en_q && tile_wr_ready;
`else
   assign wr_done = tile_wr_en_q;
`endif
   assign idle     = state_q == IDLE;
   assign in_base  = {attr_addr[ADDR_W-1:10], 10'b0};
   assign in_ok    = attr_addr[9:6] == ATTR_TABLE_OFS[9:6];
   // The next write is computed one cycle ahead so every output leaves a flop;
   // in IDLE it comes straight from the request so the first write follows acceptance.
   assign cnt_n    = idle ? 4'd0 : cnt_q + 4'd1;
   assign sel_base = idle ? in_base : base_q;
   assign sel_arow = idle ? attr_addr[5:3] : arow_q;
   assign sel_acol = idle ? attr_addr[2:0] : acol_q;
   assign sel_data = idle ? attr_data : data_q;
   assign nxt_addr = sel_base + ADDR_W'(tile_ofs(sel_arow, sel_acol, cnt_n));
   // Stop after 16 writes, or earlier when the next tile row falls below the visible rows.
   assign last     = cnt_q == 4'hF || int'({arow_q, cnt_n[3:2]}) >= NT_ROWS;
   attr_quadrant_sel u_sel (
      .attr_data(sel_data),
      .r1       (cnt_n[3]),
      .c1       (cnt_n[1]),
      .tile_pal (nxt_pal)
   );
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      base_d         = base_q;
      arow_d         = arow_q;
      acol_d         = acol_q;
      data_d         = data_q;
      attr_ready_d   = attr_ready_q;
      tile_wr_en_d   = tile_wr_en_q;
      tile_wr_addr_d = tile_wr_addr_q;
      tile_pal_d     = tile_pal_q;
      done_d         = 1'b0;
      err_d          = 1'b0;
      if (idle) begin
         if (attr_valid && attr_ready_q) begin
            if (in_ok) begin
               state_d        = EXPAND;
               cnt_d          = 4'd0;
               base_d         = in_base;
               arow_d         = attr_addr[5:3];
               acol_d         = attr_addr[2:0];
               data_d         = attr_data;
               attr_ready_d   = 1'b0;
               tile_wr_en_d   = 1'b1;
               tile_wr_addr_d = nxt_addr;
               tile_pal_d     = nxt_pal;
            end else begin
               err_d = 1'b1;
            end
         end
      end else if (wr_done) begin
         if (last) begin
            state_d      = IDLE;
            attr_ready_d = 1'b1;
            tile_wr_en_d = 1'b0;
            done_d       = 1'b1;
         end else begin
            cnt_d          = cnt_n;
            tile_wr_addr_d = nxt_addr;
            tile_pal_d     = nxt_pal;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         cnt_q          <= 4'd0;
         base_q         <= '0;
         arow_q         <= 3'd0;
         acol_q         <= 3'd0;
         data_q         <= 8'd0;
         attr_ready_q   <= 1'b1;
         tile_wr_en_q   <= 1'b0;
         tile_wr_addr_q <= '0;
         tile_pal_q     <= 2'd0;
         done_q         <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         base_q         <= base_d;
         arow_q         <= arow_d;
         acol_q         <= acol_d;
         data_q         <= data_d;
         attr_ready_q   <= attr_ready_d;
         tile_wr_en_q   <= tile_wr_en_d;
         tile_wr_addr_q <= tile_wr_addr_d;
         tile_pal_q     <= tile_pal_d;
         done_q         <= done_d;
         err_q          <= err_d;
      end
   end
   assign attr_ready   = attr_ready_q;
   assign tile_wr_en   = tile_wr_en_q;
   assign tile_wr_addr = tile_wr_addr_q;
   assign tile_pal     = tile_pal_q;
   assign done         = done_q;
   assign err          = err_q;
endmodule

// File: tb/tb_attr_expander.sv
// tb_attr_expander: directed self-checking bench for attr_expander.
module tb_attr_expander;
   logic clk, rst, attr_valid, attr_ready, tile_wr_en, done, err, tile_wr_ready;
   logic [15:0] attr_addr, tile_wr_addr;
   logic [7:0] attr_data;
   logic [1:0] tile_pal;
   int tests = 0, fails = 0;
   logic [15:0] wa[64];
   logic [1:0] wp[64];
   int nw, done_cyc;
   attr_expander dut (
      .clk         (clk),
      .rst         (rst),
      .attr_valid  (attr_valid),
      .attr_ready  (attr_ready),
      .attr_addr   (attr_addr),
      .attr_data   (attr_data),
`ifdef ATTR_EXP_BACKPRESSURE_EN
      .tile_wr_ready(tile_wr_ready),
`endif
      .tile_wr_en  (tile_wr_en),
      .tile_wr_addr(tile_wr_addr),
      .tile_pal    (tile_pal),
      .done        (done),
      .err         (err)
   );
   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end
   // Issues one request and records every write plus the cycle done is seen (0 = never).
   task automatic run_req(input logic [15:0] a, input logic [7:0] d);
      nw = 0;
      done_cyc = 0;
      attr_valid = 1; attr_addr = a; attr_data = d;
      @(negedge clk);
      attr_valid = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (tile_wr_en && nw < 64) begin wa[nw] = tile_wr_addr; wp[nw] = tile_pal; nw++; end
         if (done) begin done_cyc = cyc; break; end
         @(negedge clk);
      end
   endtask
   task automatic test_reset;
      rst = 1; attr_valid = 0; attr_addr = 0; attr_data = 0; tile_wr_ready = 1;
      repeat (2) @(negedge clk);
      tests++; if (attr_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", attr_ready); end
      tests++; if (tile_wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en got %b want 0", tile_wr_en); end
      tests++; if (tile_wr_addr !== 16'h0) begin fails++; $display("FAIL reset_addr got %h want 0000", tile_wr_addr); end
      tests++; if (tile_pal !== 2'd0) begin fails++; $display("FAIL reset_pal got %0d want 0", tile_pal); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err); end
      rst = 0;
      @(negedge clk);
   endtask
   task automatic test_top_left;
      logic [1:0] pals[16] = '{0,0,1,1, 0,0,1,1, 2,2,3,3, 2,2,3,3};
      run_req(16'h23C0, 8'hE4);
      tests++; if (nw !== 16) begin fails++; $display("FAIL tl_count got %0d want 16", nw); end
      tests++; if (done_cyc !== 17) begin fails++; $display("FAIL tl_done_cycle got %0d want 17", done_cyc); end
      tests++; if (tile_wr_en !== 1'b0 || attr_ready !== 1'b1) begin fails++; $display("FAIL tl_done_state got en=%b rdy=%b want en=0 rdy=1", tile_wr_en, attr_ready); end
      for (int i = 0; i < 16 && i < nw; i++) begin
         tests++;
         if (wa[i] !== 16'(16'h2000 + (i / 4) * 32 + i % 4) || wp[i] !== pals[i]) begin
            fails++; $display("FAIL tl_write%0d got %h/%0d want %h/%0d", i, wa[i], wp[i], 16'(16'h2000 + (i / 4) * 32 + i % 4), pals[i]);
         end
      end
      @(negedge clk);
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL tl_done_pulse got %b want 0", done); end
   endtask
   task automatic test_bottom_row;
      logic [15:0] addrs[8] = '{16'h2780, 16'h2781, 16'h2782, 16'h2783, 16'h27A0, 16'h27A1, 16'h27A2, 16'h27A3};
      logic [1:0] pals[8] = '{3, 3, 2, 2, 3, 3, 2, 2};
      logic high;
      run_req(16'h27F8, 8'h1B);
      tests++; if (nw !== 8) begin fails++; $display("FAIL br_count got %0d want 8", nw); end
      tests++; if (done_cyc !== 9) begin fails++; $display("FAIL br_done_cycle got %0d want 9", done_cyc); end
      high = 0;
      for (int i = 0; i < nw; i++) if (wa[i] >= 16'h27C0) high = 1;
      tests++; if (high !== 1'b0) begin fails++; $display("FAIL br_no_high got %b want 0", high); end
      for (int i = 0; i < 8 && i < nw; i++) begin
         tests++;
         if (wa[i] !== addrs[i] || wp[i] !== pals[i]) begin
            fails++; $display("FAIL br_write%0d got %h/%0d want %h/%0d", i, wa[i], wp[i], addrs[i], pals[i]);
         end
      end
      @(negedge clk);
   endtask
   task automatic test_invalid;
      int writes;
      attr_valid = 1; attr_addr = 16'h2100; attr_data = 8'hFF;
      @(negedge clk);
      attr_valid = 0;
      tests++; if (err !== 1'b1) begin fails++; $display("FAIL inv_err got %b want 1", err); end
      tests++; if (attr_ready !== 1'b1) begin fails++; $display("FAIL inv_ready got %b want 1", attr_ready); end
      writes = tile_wr_en ? 1 : 0;
      @(negedge clk);
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL inv_err_pulse got %b want 0", err); end
      for (int i = 0; i < 3; i++) begin
         if (tile_wr_en) writes++;
         @(negedge clk);
      end
      tests++; if (writes !== 0) begin fails++; $display("FAIL inv_writes got %0d want 0", writes); end
   endtask
   task automatic test_reset_mid;
      int writes, bad;
      attr_valid = 1; attr_addr = 16'h2BC9; attr_data = 8'h55;
      @(negedge clk);
      attr_valid = 0;
      writes = 0;
      for (int i = 0; i < 20; i++) begin
         if (tile_wr_en) writes++;
         if (writes == 5) break;
         @(negedge clk);
      end
      tests++; if (writes !== 5 || tile_wr_addr !== 16'h28A4) begin fails++; $display("FAIL rm_fifth got %0d/%h want 5/28a4", writes, tile_wr_addr); end
      rst = 1;
      @(negedge clk);
      rst = 0;
      tests++; if (tile_wr_en !== 1'b0 || attr_ready !== 1'b1) begin fails++; $display("FAIL rm_state got en=%b rdy=%b want en=0 rdy=1", tile_wr_en, attr_ready); end
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (done || tile_wr_en) bad++;
         @(negedge clk);
      end
      tests++; if (bad !== 0) begin fails++; $display("FAIL rm_quiet got %0d want 0", bad); end
   endtask
   task automatic test_back_to_back;
      int cyc1, overlap, n2, done2;
      logic [15:0] last2;
      attr_valid = 1; attr_addr = 16'h23C0; attr_data = 8'hE4;
      @(negedge clk);
      attr_addr = 16'h23C1;
      cyc1 = 0; overlap = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (done && tile_wr_en) overlap++;
         if (done) begin cyc1 = cyc; break; end
         @(negedge clk);
      end
      tests++; if (cyc1 !== 17 || attr_ready !== 1'b1) begin fails++; $display("FAIL b2b_first_done got cyc=%0d rdy=%b want 17/1", cyc1, attr_ready); end
      @(negedge clk);
      attr_valid = 0;
      tests++; if (tile_wr_en !== 1'b1 || tile_wr_addr !== 16'h2004) begin fails++; $display("FAIL b2b_second_first got en=%b addr=%h want 1/2004", tile_wr_en, tile_wr_addr); end
      n2 = 0; done2 = 0; last2 = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (done && tile_wr_en) overlap++;
         if (tile_wr_en) begin n2++; last2 = tile_wr_addr; end
         if (done) begin done2 = 1; break; end
         @(negedge clk);
      end
      tests++; if (done2 !== 1 || n2 !== 16 || last2 !== 16'h2067) begin fails++; $display("FAIL b2b_second got done=%0d n=%0d last=%h want 1/16/2067", done2, n2, last2); end
      tests++; if (overlap !== 0) begin fails++; $display("FAIL b2b_overlap got %0d want 0", overlap); end
      @(negedge clk);
   endtask
`ifdef ATTR_EXP_BACKPRESSURE_EN
   task automatic test_backpressure;
      int stall_left, stalled, completed, dcyc;
      logic started;
      attr_valid = 1; attr_addr = 16'h23C0; attr_data = 8'hE4;
      @(negedge clk);
      attr_valid = 0;
      stall_left = 0; stalled = 0; completed = 0; dcyc = 0; started = 0;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         if (done) begin dcyc = cyc; break; end
         if (tile_wr_en && tile_wr_addr == 16'h2001 && !started) begin started = 1; stall_left = 3; end
         tile_wr_ready = stall_left == 0;
         if (tile_wr_en && tile_wr_ready) completed++;
         if (tile_wr_en && !tile_wr_ready && tile_wr_addr == 16'h2001) stalled++;
         if (stall_left > 0) stall_left--;
         @(negedge clk);
      end
      tile_wr_ready = 1;
      tests++; if (stalled !== 3) begin fails++; $display("FAIL bp_held got %0d want 3", stalled); end
      tests++; if (completed !== 16) begin fails++; $display("FAIL bp_writes got %0d want 16", completed); end
      tests++; if (dcyc !== 20) begin fails++; $display("FAIL bp_done_cycle got %0d want 20", dcyc); end
      @(negedge clk);
   endtask
`endif
   initial begin
      test_reset;
      test_top_left;
      test_bottom_row;
      test_invalid;
      test_reset_mid;
      test_back_to_back;
`ifdef ATTR_EXP_BACKPRESSURE_EN
      test_backpressure;
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
